// File: rtl/count_mod_n.sv
// Programmable modulo-(limit+1) up/down counter with parallel load, terminal-count pulse and one-shot stop.
// Latency: out/tc/done are registered and reflect an edge's inputs right after that edge, with no input-to-output path.
// Backpressure: none; en gates counting, load overrides en, and clr aborts everything asynchronously.
module count_mod_n #(
    parameter int WIDTH = 5    // legal range 2..16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             oneshot,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt;
    logic             done_nxt;

    // Next-state selection: load beats counting; a finished one-shot run holds until reloaded.
    always_comb begin
        out_nxt  = out;
        tc_nxt   = 1'b0;
        done_nxt = done;
        if (load) begin
            // Clamp so the count never starts outside 0..limit.
            out_nxt  = (load_val > limit) ? limit : load_val;
            done_nxt = 1'b0;
        end else if (en && !done) begin
            if (dir) begin
                // ">=" also recovers a count left above a freshly lowered limit.
                if (out >= limit) begin
                    tc_nxt = 1'b1;
                    if (oneshot) begin
                        out_nxt  = limit;
                        done_nxt = 1'b1;
                    end else begin
                        out_nxt = '0;
                    end
                end else begin
                    out_nxt = out + WIDTH'(1);
                end
            end else begin
                if (out > limit) begin
                    // Limit was lowered under a running count: snap to it without a terminal event.
                    out_nxt = limit;
                end else if (out == '0) begin
                    tc_nxt = 1'b1;
                    if (oneshot) begin
                        done_nxt = 1'b1;
                    end else begin
                        out_nxt = limit;
                    end
                end else begin
                    out_nxt = out - WIDTH'(1);
                end
            end
        end
    end

    // State registers; clr clears immediately and masks every other input.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            out  <= out_nxt;
            tc   <= tc_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_count_mod_n.sv
module tb_count_mod_n;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         clr, en, dir, load, oneshot;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] out;
    logic         tc, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, advanced from the behavioural rules with integer arithmetic.
    int m_out;
    bit m_tc, m_done;

    always #5 clk = ~clk;

    count_mod_n #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .limit(limit), .oneshot(oneshot),
        .out(out), .tc(tc), .done(done)
    );

    task automatic model_reset();
        m_out = 0; m_tc = 0; m_done = 0;
    endtask

    // One rising edge of the abstract counter: range is 0..lim, arithmetic modulo lim+1.
    task automatic model_edge();
        int lim;
        lim = int'(limit);
        m_tc = 0;
        if (load) begin
            m_out  = (int'(load_val) < lim) ? int'(load_val) : lim;
            m_done = 0;
        end else if (en && !m_done) begin
            if (dir) begin
                if (m_out >= lim) begin
                    m_tc = 1;
                    if (oneshot) begin m_out = lim; m_done = 1; end
                    else m_out = 0;
                end else m_out = (m_out + 1) % (lim + 1);
            end else begin
                if (m_out > lim) m_out = lim;
                else if (m_out == 0) begin
                    m_tc = 1;
                    if (oneshot) m_done = 1;
                    else m_out = lim;
                end else m_out = (m_out + lim) % (lim + 1);
            end
        end
    endtask

    // Advance one edge and leave the time 1 unit after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        if (!clr) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; dir = 1; load = 0; load_val = '0; limit = 5'd31; oneshot = 0;
    endtask

    task automatic test_reset();
        clr = 1; en = 1; dir = 1; load = 1; load_val = 5'd9; limit = 5'd20; oneshot = 1;
        #2;
        repeat (2) tick();
        n_cmp++; if (out !== 5'd0) begin n_bad++; $display("FAIL reset_out: got %0d want 0", out); end
        n_cmp++; if (tc !== 1'b0) begin n_bad++; $display("FAIL reset_tc: got %b want 0", tc); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        idle_inputs();
        clr = 0;
        model_reset();
    endtask

    task automatic test_async_clr();
        idle_inputs(); load = 1; load_val = 0; tick(); load = 0;
        en = 1;
        repeat (13) tick();
        n_cmp++; if (out !== 5'd13) begin n_bad++; $display("FAIL aclr_pre: out got %0d want 13", out); end
        #3 clr = 1;
        #1;
        n_cmp++; if (out !== 5'd0 || tc !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL aclr_async: out/tc/done got %0d/%b/%b want 0/0/0", out, tc, done);
        end
        model_reset();
        #1 clr = 0;
        tick();
        n_cmp++; if (out !== 5'd1 || tc !== 1'b0) begin
            n_bad++; $display("FAIL aclr_resume: out/tc got %0d/%b want 1/0", out, tc);
        end
    endtask

    task automatic test_wrap_up();
        int tcs;
        idle_inputs(); load = 1; load_val = 0; tick(); load = 0;
        en = 1; tcs = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            n_cmp++; if (out !== 5'(i % 32) || tc !== (i == 32)) begin
                n_bad++; $display("FAIL wrap_up[%0d]: out/tc got %0d/%b want %0d/%b", i, out, tc, i % 32, i == 32);
            end
            if (tc) tcs++;
        end
        n_cmp++; if (tcs != 1) begin n_bad++; $display("FAIL wrap_up_tc_count: got %0d want 1", tcs); end
    endtask

    task automatic test_down_load();
        int exp_seq [5] = '{2, 1, 0, 9, 8};
        idle_inputs(); limit = 5'd9; dir = 0; load_val = 5'd3; load = 1; tick(); load = 0;
        n_cmp++; if (out !== 5'd3) begin n_bad++; $display("FAIL down_load: out got %0d want 3", out); end
        en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out !== 5'(exp_seq[i]) || tc !== (i == 3)) begin
                n_bad++; $display("FAIL down_seq[%0d]: out/tc got %0d/%b want %0d/%b", i, out, tc, exp_seq[i], i == 3);
            end
        end
    endtask

    task automatic test_oneshot();
        int tcs;
        idle_inputs(); limit = 5'd5; oneshot = 1; load = 1; load_val = 0; tick(); load = 0;
        en = 1; tcs = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (out !== 5'(i < 5 ? i : 5) || tc !== m_tc || done !== m_done) begin
                n_bad++; $display("FAIL oneshot[%0d]: out/tc/done got %0d/%b/%b want %0d/%b/%b",
                                  i, out, tc, done, (i < 5 ? i : 5), m_tc, m_done);
            end
            if (tc) tcs++;
        end
        n_cmp++; if (done !== 1'b1 || tcs != 1) begin
            n_bad++; $display("FAIL oneshot_end: done/tc pulses got %b/%0d want 1/1", done, tcs);
        end
        en = 0; load = 1; load_val = 5'd2; tick(); load = 0;
        n_cmp++; if (out !== 5'd2 || done !== 1'b0) begin
            n_bad++; $display("FAIL oneshot_reload: out/done got %0d/%b want 2/0", out, done);
        end
    endtask

    task automatic test_limit_lower();
        for (int pass = 0; pass < 2; pass++) begin
            idle_inputs(); limit = 5'd12; load_val = 5'd20; load = 1; tick(); load = 0;
            n_cmp++; if (out !== 5'd12) begin n_bad++; $display("FAIL load_clamp[%0d]: out got %0d want 12", pass, out); end
            limit = 5'd4; dir = (pass == 0); en = 1; tick();
            n_cmp++; if (out !== (pass == 0 ? 5'd0 : 5'd4) || tc !== (pass == 0)) begin
                n_bad++; $display("FAIL limit_lower[%0d]: out/tc got %0d/%b want %0d/%b",
                                  pass, out, tc, (pass == 0 ? 0 : 4), pass == 0);
            end
        end
    endtask

    task automatic test_load_priority();
        idle_inputs(); en = 1; tick(); tick();
        load = 1; load_val = 5'd7; tick(); load = 0;
        n_cmp++; if (out !== 5'd7 || tc !== 1'b0) begin
            n_bad++; $display("FAIL load_over_en: out/tc got %0d/%b want 7/0", out, tc);
        end
        limit = 5'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out !== 5'd0 || tc !== 1'b1) begin
                n_bad++; $display("FAIL limit0[%0d]: out/tc got %0d/%b want 0/1", i, out, tc);
            end
        end
        dir = 0; tick();
        n_cmp++; if (out !== 5'd0 || tc !== 1'b1) begin
            n_bad++; $display("FAIL limit0_down: out/tc got %0d/%b want 0/1", out, tc);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            dir      = $urandom_range(0, 1);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 5'($urandom);
            oneshot  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) limit = 5'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2 clr = 1;
                #1 model_reset();
                #1 clr = 0;
            end
            tick();
            n_cmp++; if (out !== 5'(m_out) || tc !== m_tc || done !== m_done) begin
                n_bad++; $display("FAIL random[%0d]: out/tc/done got %0d/%b/%b want %0d/%b/%b",
                                  i, out, tc, done, m_out, m_tc, m_done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_async_clr();
        test_wrap_up();
        test_down_load();
        test_oneshot();
        test_limit_lower();
        test_load_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
